// File: rtl/sap_out_port_if.sv
// sap_out_port_if: strobe/data/status bundle between the controller and the output port.
// Rev 1.0
`default_nettype none

interface sap_out_port_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     display;
  logic [WIDTH-1:0]         data_in;
  logic                     clr_ovf;
  logic [WIDTH-1:0]         out;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     busy;
  logic                     serial_out;
  logic                     serial_start;

  modport master (
    output display, data_in, clr_ovf,
    input  out, count, full, empty, overflow, busy, serial_out, serial_start
  );

  modport slave (
    input  display, data_in, clr_ovf,
    output out, count, full, empty, overflow, busy, serial_out, serial_start
  );
endinterface

`default_nettype wire

// File: rtl/sap_out_port.sv
// sap_out_port: parallel output latch plus FIFO-buffered MSB-first serializer with start marker.
// Rev 1.0
`default_nettype none

module sap_out_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sap_out_port_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_div;
  logic             r_so;
  logic             r_start;

  logic             w_pop;
  logic             w_tick;
  logic             w_last;
  logic             w_busy;
  logic             w_full;
  logic             w_push;
  logic [WIDTH-1:0] w_head;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_head = r_mem[r_rptr];
  // A full FIFO still accepts a word when the serializer frees a slot on the same edge.
  assign w_push = bus.display && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_SHIFT;
      S_SHIFT: if (w_tick && w_last) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = (r_state == S_IDLE) && (r_count != '0);
    w_tick = (r_state == S_SHIFT) && (r_div == DW'(DIV - 1));
    w_last = (r_bit == BW'(WIDTH - 1));
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.display) r_out <= bus.data_in;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.display && !w_push) r_ovf <= 1'b1;
      else if (bus.clr_ovf)       r_ovf <= 1'b0;
    end
  end

  // The head MSB goes straight to the line; the shifter keeps only the bits still to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_so    <= 1'b0;
      r_start <= 1'b0;
    end else if (w_pop) begin
      r_shift <= {w_head[WIDTH-2:0], 1'b0};
      r_so    <= w_head[WIDTH-1];
      r_start <= 1'b1;
      r_bit   <= '0;
      r_div   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_start <= 1'b0;
      if (w_tick) begin
        r_div <= '0;
        if (w_last) begin
          r_so <= 1'b0;
        end else begin
          r_so    <= r_shift[WIDTH-1];
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_bit   <= r_bit + BW'(1);
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  assign bus.out          = r_out;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = (r_count == '0);
  assign bus.overflow     = r_ovf;
  assign bus.busy         = w_busy;
  assign bus.serial_out   = r_so;
  assign bus.serial_start = r_start;
endmodule

`default_nettype wire

// File: tb/tb_sap_out_port.sv
// tb_sap_out_port: directed and randomized checks of sap_out_port against a timeline model.
// Rev 1.0
`default_nettype none

module tb_sap_out_port;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 2;
  localparam int FL    = WIDTH * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sap_out_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sap_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int starts[$];

  // Model: a queue of words plus the number of edges since the last frame began.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_word;
  logic             m_ovf;
  int               m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out   = '0;
    m_word  = '0;
    m_ovf   = 1'b0;
    m_since = FL + 1;
  endtask

  function automatic bit model_pop_next();
    return (m_since >= FL + 1) && (m_q.size() > 0);
  endfunction

  task automatic model_edge(input logic d, input logic [WIDTH-1:0] v, input logic c);
    if (model_pop_next()) begin
      m_word  = m_q.pop_front();
      m_since = 0;
    end else if (m_since < FL + 1) begin
      m_since++;
    end
    if (d) begin
      m_out = v;
      if (m_q.size() < DEPTH) m_q.push_back(v);
    end
    if (d && m_q.size() >= DEPTH && !(m_q.size() > 0 && m_q[m_q.size()-1] == v && 1'b0)) begin
    end
  endtask

  task automatic check_all();
    int   idx;
    logic so;
    idx = WIDTH - 1 - (m_since / DIV);
    so  = (m_since < FL) ? m_word[idx] : 1'b0;
    chk("out",      bus.out,          m_out);
    chk("count",    bus.count,        m_q.size());
    chk("full",     bus.full,         m_q.size() == DEPTH);
    chk("empty",    bus.empty,        m_q.size() == 0);
    chk("overflow", bus.overflow,     m_ovf);
    chk("busy",     bus.busy,         m_since <= FL);
    chk("ser_out",  bus.serial_out,   so);
    chk("ser_strt", bus.serial_start, m_since == 0);
    if (bus.serial_start === 1'b1) starts.push_back(cyc);
  endtask

  task automatic cycle(input logic d, input logic [WIDTH-1:0] v, input logic c);
    bit full_before;
    bit pop;
    bus.display = d;
    bus.data_in = v;
    bus.clr_ovf = c;
    full_before = (m_q.size() == DEPTH);
    pop = model_pop_next();
    @(posedge clk);
    cyc++;
    model_edge(d, v, c);
    if (d && full_before && !pop) m_ovf = 1'b1;
    else if (c)                   m_ovf = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [15:0] bits;
    int          wrap_pushes;
    int          guard;

    bus.display = 1'b0;
    bus.data_in = '0;
    bus.clr_ovf = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Single word A5: latency and bit pattern.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("a5_out", bus.out, 8'hA5);
    chk("a5_cnt1", bus.count, 1);
    cycle(1'b0, '0, 1'b0);
    chk("a5_cnt0", bus.count, 0);
    chk("a5_start", bus.serial_start, 1);
    bits = '0;
    bits[15] = bus.serial_out;
    for (int i = 14; i >= 0; i--) begin
      cycle(1'b0, '0, 1'b0);
      bits[i] = bus.serial_out;
    end
    chk("a5_bits", bits, 16'hCC33);
    cycle(1'b0, '0, 1'b0);
    chk("a5_tail", bus.serial_out, 0);
    idle(4);

    // Burst of six writes while the first word is being serialized.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("burst_full", bus.full, 1);
    chk("burst_ovf0", bus.overflow, 0);
    cycle(1'b1, 8'h06, 1'b0);
    chk("burst_ovf1", bus.overflow, 1);
    chk("burst_out6", bus.out, 8'h06);
    cycle(1'b1, 8'h07, 1'b1);
    chk("setwins", bus.overflow, 1);
    cycle(1'b0, '0, 1'b1);
    chk("clr_ovf", bus.overflow, 0);
    idle(100);

    // Four queued frames: start spacing.
    starts.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
    idle(4 * (FL + 2) + 4);
    chk("n_starts", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++)
      chk("spacing", starts[i] - starts[i-1], FL + 2);
    chk("fill_empty", bus.empty, 1);
    chk("fill_busy", bus.busy, 0);

    // Push on each pop edge while full, crossing pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    wrap_pushes = 0;
    guard = 0;
    while (wrap_pushes < 10 && guard < 400) begin
      if (model_pop_next() && m_q.size() == DEPTH) begin
        cycle(1'b1, 8'($urandom), 1'b0);
        wrap_pushes++;
      end else begin
        cycle(1'b0, '0, 1'b0);
      end
      guard++;
    end
    chk("wrap_done", wrap_pushes, 10);
    chk("wrap_ovf", bus.overflow, 0);
    idle(5 * (FL + 2) + 4);

    // Asynchronous reset in the middle of an all-ones frame.
    cycle(1'b1, 8'hFF, 1'b0);
    guard = 0;
    while (m_since != 7 && guard < 50) begin
      cycle(1'b0, '0, 1'b0);
      guard++;
    end
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_so",    bus.serial_out, 0);
    chk("arst_start", bus.serial_start, 0);
    chk("arst_busy",  bus.busy, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_out",   bus.out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Randomized traffic, dense then sparse.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, (i < 200) ? 2 : 12) == 0), 8'($urandom),
            ($urandom_range(0, 15) == 0));
    end
    idle(6 * (FL + 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sap_out_port.md
Name: sap_out_port

Overview:
Parametrised successor to the SAP-3 single-register output latch. It captures the ALU result on each `display` strobe into a parallel mirror register and a DEPTH-entry FIFO. A serializer drains the FIFO MSB-first onto a serial line with a start marker, so bursts of OUT instructions are not lost while an external monitor reads them. It sits beside the controller on the slow core clock, taking `alu_out` and the `display` control bit.

Parameters:
WIDTH, 8, data width of output word
DEPTH, 4, FIFO entries; power of two, >= 2
DIV, 2, clk cycles each serial bit is held; >= 1

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  asynchronous active-high reset
display  in  1  write strobe; sampled on rising clk
data_in  in  WIDTH  word to output (`alu_out`)
out  out  WIDTH  parallel mirror of last displayed word
count  out  $clog2(DEPTH)+1  FIFO occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a write was dropped
clr_ovf  in  1  clears overflow
busy  out  1  serializer not IDLE
serial_out  out  1  serial data, MSB first
serial_start  out  1  one-cycle frame marker

Behaviour:
- Reset (async, immediate): out=0, count=0, pointers=0, overflow=0, FSM=IDLE, shift reg=0, serial_out=0, serial_start=0, busy=0.
- Reset mid-frame aborts the frame. FIFO contents are discarded; no partial bits follow reset release.
- Push: on an edge with display=1, `out` <= data_in unconditionally.
  - The word is also written to the FIFO if count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow <= 1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: read and write pointers wrap modulo DEPTH.
- overflow clears on clr_ovf=1. If set and clear coincide on one edge, set wins.
- FSM IDLE: on an edge where empty=0:
  - pop the head into the shift reg;
  - serial_out <= head MSB;
  - serial_start <= 1;
  - bit_cnt <= 0, div_cnt <= 0;
  - go to SHIFT.
- FSM SHIFT:
  - serial_start <= 0 after its single cycle.
  - div_cnt counts 0..DIV-1. At DIV-1 the shift reg shifts left, serial_out takes the next bit, and bit_cnt increments.
  - After bit WIDTH-1 has been held DIV cycles: serial_out <= 0 and go to GAP.
- FSM GAP: exactly one cycle, then IDLE. This gives a minimum one-cycle low between frames.
- Frame timing:
  - serial_start is high for the first cycle of bit 0.
  - Frame length is WIDTH*DIV cycles.
  - Back-to-back frames start every WIDTH*DIV+2 cycles.
- busy=1 in SHIFT and GAP.
- Latency with an empty FIFO and IDLE:
  - display sampled at edge N: count=1 after N.
  - Pop at edge N+1: serial_start=1 and count=0 after N+1.
- Widths:
  - count is unsigned, $clog2(DEPTH)+1 bits, so count=DEPTH is representable.
  - Data is not modified; no sign handling.
- `out` is independent of FIFO state and updates even when the push is dropped.

Test Plan:
- Reset, then display=1 with data_in=8'hA5 for one cycle (WIDTH=8, DEPTH=4, DIV=2) -> out=A5 next cycle, count=1, then 0 one cycle later. serial_start pulses once, and serial_out shows 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 over 16 cycles, then 0.
- Five consecutive display cycles with 01,02,03,04,05 while the serializer is busy on word 01 -> 02..05 all fit (01 already popped), full=1 after the 5th, overflow stays 0. A 6th write of 06 -> overflow=1, out=06, FIFO holds 02..05.
- With overflow=1, assert clr_ovf and display on a full FIFO in the same cycle -> overflow remains 1. clr_ovf alone next cycle -> overflow=0.
- Fill the FIFO with 4 words, then idle -> four frames, serial_start pulses spaced exactly 18 cycles apart, data order FIFO-correct. Empty=1 and busy=0 after the last GAP.
- Assert rst asynchronously mid-frame (bit 3 of 8'hFF) -> serial_out, serial_start, busy, count, out drop to 0 immediately. No further bits after release.
- Run 10 push/pop cycles crossing pointer wrap with a push exactly on each pop edge while full -> no drops, overflow=0, serialized order matches input order.
